// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage between the AGEX latch and WB.
// Passes non-memory ops through in one cycle. Aligned loads and stores go
// through a small IDLE/REQ/WAIT handshake with the data memory. Misaligned
// memory ops complete without touching memory and raise misalign_err.
// Also drives the MEM->AGEX/DE forwarding path and counts stall cycles.
module mem_stage #(
    parameter int DBITS     = 32,
    parameter int REGNOBITS = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    // upstream AGEX latch
    input  logic                 in_valid,
    input  logic                 in_is_load,
    input  logic                 in_is_store,
    input  logic                 in_wr_reg,
    input  logic [REGNOBITS-1:0] in_rd,
    input  logic [DBITS-1:0]     in_pc,
    input  logic [DBITS-1:0]     in_result,
    input  logic [DBITS-1:0]     in_addr,
    input  logic [DBITS-1:0]     in_wdata,
    output logic                 in_ready,
    // data memory request
    output logic                 dmem_req_valid,
    output logic                 dmem_req_we,
    output logic [DBITS-1:0]     dmem_req_addr,
    output logic [DBITS-1:0]     dmem_req_wdata,
    input  logic                 dmem_req_ready,
    // data memory response
    input  logic                 dmem_rsp_valid,
    input  logic [DBITS-1:0]     dmem_rsp_data,
    // MEM latch to WB
    output logic                 out_valid,
    output logic                 out_wr_reg,
    output logic [REGNOBITS-1:0] out_rd,
    output logic [DBITS-1:0]     out_pc,
    output logic [DBITS-1:0]     out_data,
    // forwarding
    output logic                 fwd_valid,
    output logic [REGNOBITS-1:0] fwd_rd,
    output logic [DBITS-1:0]     fwd_data,
    // status
    output logic                 misalign_err,
    output logic [31:0]          stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                 state_r;
    logic                   in_ready_r;
    logic                   req_valid_r;
    logic                   req_we_r;

    // holding registers captured at acceptance
    logic                   hold_is_store_r;
    logic                   hold_wr_reg_r;
    logic [REGNOBITS-1:0]   hold_rd_r;
    logic [DBITS-1:0]       hold_pc_r;
    logic [DBITS-1:0]       hold_result_r;
    logic [DBITS-1:0]       hold_addr_r;
    logic [DBITS-1:0]       hold_wdata_r;

    // MEM latch
    logic                   out_valid_r;
    logic                   out_wr_reg_r;
    logic [REGNOBITS-1:0]   out_rd_r;
    logic [DBITS-1:0]       out_pc_r;
    logic [DBITS-1:0]       out_data_r;
    logic                   misalign_r;
    logic [31:0]            stall_cnt_r;

    logic                   accept_s;
    logic                   is_mem_s;
    logic                   misaligned_s;

    // Decode the incoming instruction; a load+store combination counts as a store
    // because the request direction comes from in_is_store alone.
    always_comb begin
        accept_s     = in_valid & in_ready_r;
        is_mem_s     = in_is_load | in_is_store;
        misaligned_s = (in_addr[1:0] != 2'b00);
    end

    // Stage FSM: acceptance, memory handshake and MEM latch update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            in_ready_r      <= 1'b1;
            req_valid_r     <= 1'b0;
            req_we_r        <= 1'b0;
            hold_is_store_r <= 1'b0;
            hold_wr_reg_r   <= 1'b0;
            hold_rd_r       <= {REGNOBITS{1'b0}};
            hold_pc_r       <= {DBITS{1'b0}};
            hold_result_r   <= {DBITS{1'b0}};
            hold_addr_r     <= {DBITS{1'b0}};
            hold_wdata_r    <= {DBITS{1'b0}};
            out_valid_r     <= 1'b0;
            out_wr_reg_r    <= 1'b0;
            out_rd_r        <= {REGNOBITS{1'b0}};
            out_pc_r        <= {DBITS{1'b0}};
            out_data_r      <= {DBITS{1'b0}};
            misalign_r      <= 1'b0;
        end else begin
            // completion and error are single-cycle pulses
            out_valid_r <= 1'b0;
            misalign_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        hold_is_store_r <= in_is_store;
                        hold_wr_reg_r   <= in_wr_reg;
                        hold_rd_r       <= in_rd;
                        hold_pc_r       <= in_pc;
                        hold_result_r   <= in_result;
                        hold_addr_r     <= in_addr;
                        hold_wdata_r    <= in_wdata;
                        if (!is_mem_s) begin
                            out_valid_r  <= 1'b1;
                            out_wr_reg_r <= in_wr_reg;
                            out_rd_r     <= in_rd;
                            out_pc_r     <= in_pc;
                            out_data_r   <= in_result;
                        end else if (misaligned_s) begin
                            // complete immediately with no register write
                            out_valid_r  <= 1'b1;
                            out_wr_reg_r <= 1'b0;
                            out_rd_r     <= in_rd;
                            out_pc_r     <= in_pc;
                            out_data_r   <= in_result;
                            misalign_r   <= 1'b1;
                        end else begin
                            state_r     <= ST_REQ;
                            in_ready_r  <= 1'b0;
                            req_valid_r <= 1'b1;
                            req_we_r    <= in_is_store;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) begin
                        req_valid_r <= 1'b0;
                        req_we_r    <= 1'b0;
                        if (hold_is_store_r) begin
                            state_r      <= ST_IDLE;
                            in_ready_r   <= 1'b1;
                            out_valid_r  <= 1'b1;
                            out_wr_reg_r <= 1'b0;
                            out_rd_r     <= hold_rd_r;
                            out_pc_r     <= hold_pc_r;
                            out_data_r   <= hold_result_r;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rsp_valid) begin
                        state_r      <= ST_IDLE;
                        in_ready_r   <= 1'b1;
                        out_valid_r  <= 1'b1;
                        out_wr_reg_r <= hold_wr_reg_r;
                        out_rd_r     <= hold_rd_r;
                        out_pc_r     <= hold_pc_r;
                        out_data_r   <= dmem_rsp_data;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    req_valid_r <= 1'b0;
                    req_we_r    <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles spent waiting on memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if ((state_r == ST_REQ || state_r == ST_WAIT) &&
                     (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign in_ready       = in_ready_r;
    assign dmem_req_valid = req_valid_r;
    assign dmem_req_we    = req_we_r;
    assign dmem_req_addr  = hold_addr_r;
    assign dmem_req_wdata = hold_wdata_r;

    assign out_valid      = out_valid_r;
    assign out_wr_reg     = out_wr_reg_r;
    assign out_rd         = out_rd_r;
    assign out_pc         = out_pc_r;
    assign out_data       = out_data_r;

    // forwarding never advertises writes to the zero register
    assign fwd_valid      = out_valid_r & out_wr_reg_r & (out_rd_r != {REGNOBITS{1'b0}});
    assign fwd_rd         = out_rd_r;
    assign fwd_data       = out_data_r;

    assign misalign_err   = misalign_r;
    assign stall_cnt      = stall_cnt_r;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected completions into a
// queue, a negedge monitor pops and compares each out_valid pulse.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        in_valid, in_is_load, in_is_store, in_wr_reg;
    logic [4:0]  in_rd;
    logic [31:0] in_pc, in_result, in_addr, in_wdata;
    logic        in_ready;
    logic        dmem_req_valid, dmem_req_we, dmem_req_ready;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic        out_valid, out_wr_reg;
    logic [4:0]  out_rd;
    logic [31:0] out_pc, out_data;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        misalign_err;
    logic [31:0] stall_cnt;

    typedef struct packed {
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] data;
        logic        fwd;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] exp_stall;

    mem_stage #(.DBITS(32), .REGNOBITS(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_wr_reg(in_wr_reg), .in_rd(in_rd), .in_pc(in_pc),
        .in_result(in_result), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_ready(in_ready),
        .dmem_req_valid(dmem_req_valid), .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_ready(dmem_req_ready),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
        .out_valid(out_valid), .out_wr_reg(out_wr_reg), .out_rd(out_rd),
        .out_pc(out_pc), .out_data(out_data),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .misalign_err(misalign_err), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic wr, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] res,
                         input logic [31:0] addr, input logic [31:0] wd);
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_wr_reg   = wr;
        in_rd       = rd;
        in_pc       = pc;
        in_result   = res;
        in_addr     = addr;
        in_wdata    = wd;
    endtask

    task automatic expect_out(input logic wr, input logic [4:0] rd, input logic [31:0] pc,
                              input logic [31:0] data, input logic fwd, input logic mis);
        exp_t e;
        e.wr = wr; e.rd = rd; e.pc = pc; e.data = data; e.fwd = fwd; e.mis = mis;
        q.push_back(e);
    endtask

    // Monitor: every out_valid pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_wr_reg", {63'd0, out_wr_reg}, {63'd0, e.wr});
                    chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                    chk("out_pc", {32'd0, out_pc}, {32'd0, e.pc});
                    chk("out_data", {32'd0, out_data}, {32'd0, e.data});
                    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e.fwd});
                    chk("fwd_data", {32'd0, fwd_data}, {32'd0, e.data});
                    chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, e.rd});
                    chk("misalign_err", {63'd0, misalign_err}, {63'd0, e.mis});
                end
            end else begin
                chk("misalign_idle", {63'd0, misalign_err}, 64'd0);
                chk("fwd_idle", {63'd0, fwd_valid}, 64'd0);
            end
        end
    end

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_wr_reg = 1'b0;
        in_rd = 5'd0; in_pc = 32'd0; in_result = 32'd0; in_addr = 32'd0; in_wdata = 32'd0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = 32'd0;
        exp_stall = 32'd0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_req_valid", {63'd0, dmem_req_valid}, 64'd0);
        chk("rst_stall", {32'd0, stall_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;

        // back-to-back ALU ops
        issue(1'b0, 1'b0, 1'b1, 5'd3, 32'h1000, 32'd5, 32'h0, 32'h0);
        expect_out(1'b1, 5'd3, 32'h1000, 32'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_out_valid0", {63'd0, out_valid}, 64'd1);
        chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        issue(1'b0, 1'b0, 1'b1, 5'd3, 32'h1004, 32'd7, 32'h0, 32'h0);
        expect_out(1'b1, 5'd3, 32'h1004, 32'd7, 1'b1, 1'b0);
        @(negedge clk);
        chk("b2b_out_valid1", {63'd0, out_valid}, 64'd1);
        // write to r0: completes but does not forward
        issue(1'b0, 1'b0, 1'b1, 5'd0, 32'h1008, 32'd9, 32'h0, 32'h0);
        expect_out(1'b1, 5'd0, 32'h1008, 32'd9, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        // response in IDLE must be ignored
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hBAD0BAD0;
        @(negedge clk);
        chk("idle_no_out", {63'd0, out_valid}, 64'd0);
        dmem_rsp_valid = 1'b0;
        @(negedge clk);

        // aligned load, ready in first REQ cycle, response two cycles later
        issue(1'b1, 1'b0, 1'b1, 5'd5, 32'h2000, 32'h11, 32'h100, 32'h0);
        expect_out(1'b1, 5'd5, 32'h2000, 32'hDEADBEEF, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ld_req_valid", {63'd0, dmem_req_valid}, 64'd1);
        chk("ld_req_we", {63'd0, dmem_req_we}, 64'd0);
        chk("ld_req_addr", {32'd0, dmem_req_addr}, 64'h100);
        chk("ld_in_ready", {63'd0, in_ready}, 64'd0);
        chk("ld_out_valid", {63'd0, out_valid}, 64'd0);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        chk("ld_wait_req_valid", {63'd0, dmem_req_valid}, 64'd0);
        chk("ld_wait_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'hDEADBEEF;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        exp_stall = exp_stall + 32'd3;
        chk("ld_stall", {32'd0, stall_cnt}, {32'd0, exp_stall});
        chk("ld_in_ready_back", {63'd0, in_ready}, 64'd1);

        // store with ready held low for three cycles
        issue(1'b0, 1'b1, 1'b1, 5'd7, 32'h3000, 32'h204, 32'h204, 32'h55);
        expect_out(1'b0, 5'd7, 32'h3000, 32'h204, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("st_req_valid", {63'd0, dmem_req_valid}, 64'd1);
            chk("st_req_we", {63'd0, dmem_req_we}, 64'd1);
            chk("st_req_addr", {32'd0, dmem_req_addr}, 64'h204);
            chk("st_req_wdata", {32'd0, dmem_req_wdata}, 64'h55);
            chk("st_in_ready", {63'd0, in_ready}, 64'd0);
            if (i == 3) dmem_req_ready = 1'b1;
            @(negedge clk);
        end
        dmem_req_ready = 1'b0;
        exp_stall = exp_stall + 32'd4;
        chk("st_stall", {32'd0, stall_cnt}, {32'd0, exp_stall});
        chk("st_req_done", {63'd0, dmem_req_valid}, 64'd0);

        // misaligned load
        issue(1'b1, 1'b0, 1'b1, 5'd4, 32'h4000, 32'h77, 32'h102, 32'h0);
        expect_out(1'b0, 5'd4, 32'h4000, 32'h77, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mis_no_req", {63'd0, dmem_req_valid}, 64'd0);
        chk("mis_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        chk("mis_stall", {32'd0, stall_cnt}, {32'd0, exp_stall});

        // load+store together behaves as a store
        issue(1'b1, 1'b1, 1'b1, 5'd8, 32'h5000, 32'h300, 32'h300, 32'hAA);
        expect_out(1'b0, 5'd8, 32'h5000, 32'h300, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ldst_req_we", {63'd0, dmem_req_we}, 64'd1);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;

        // reset during WAIT abandons the access
        issue(1'b1, 1'b0, 1'b1, 5'd6, 32'h6000, 32'h0, 32'h400, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_out_data", {32'd0, out_data}, 64'd0);
        chk("arst_out_rd", {59'd0, out_rd}, 64'd0);
        chk("arst_out_pc", {32'd0, out_pc}, 64'd0);
        chk("arst_req_valid", {63'd0, dmem_req_valid}, 64'd0);
        chk("arst_stall", {32'd0, stall_cnt}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        // first edge after reset accepts; the stale response is ignored
        reset = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rsp_data = 32'h1234;
        issue(1'b0, 1'b0, 1'b1, 5'd2, 32'h7000, 32'h42, 32'h0, 32'h0);
        expect_out(1'b1, 5'd2, 32'h7000, 32'h42, 1'b1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("post_rst_no_out", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("scoreboard_empty", {32'd0, q.size()}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
